// File: rtl/video_fetch_pkg.sv
// Shared types and constants for the framebuffer fetch path.
package video_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    REQ,
    DATA
  } fetch_state_t;

  localparam int DEFAULT_BURST_WORDS = 8;

endpackage

// File: rtl/video_fetch_fifo.sv
// Synchronous FIFO with flush, occupancy/free counts and a registered head word.
// Storage has no reset so it maps onto block RAM; the head register reads ahead.
module video_fetch_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   free
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_reg [DEPTH];
  logic [WIDTH-1:0]      head_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  do_push;
  logic                  do_pop;
  logic                  full;

  assign full        = (count_reg == (DEPTH_LOG2 + 1)'(DEPTH));
  assign do_push     = push && !flush;
  assign do_pop      = pop && !flush && (count_reg != '0);
  assign rd_ptr_next = flush ? '0 : rd_ptr_reg + DEPTH_LOG2'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Read the word that will be at the head next cycle; bypass a same-cycle write to it.
  always_ff @(posedge clk) begin
    if (do_push && (wr_ptr_reg == rd_ptr_next)) head_reg <= push_data;
    else                                        head_reg <= mem_reg[rd_ptr_next];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
        if (do_push && !do_pop)      count_reg <= count_reg + (DEPTH_LOG2 + 1)'(1);
        else if (!do_push && do_pop) count_reg <= count_reg - (DEPTH_LOG2 + 1)'(1);
      end
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n) !(do_push && full));

  assign head  = head_reg;
  assign count = count_reg;
  assign free  = (DEPTH_LOG2 + 1)'(DEPTH) - count_reg;

endmodule

// File: rtl/video_fetch.sv
// Framebuffer prefetcher: bursts line data into a FIFO ahead of the raster and
// hands out one registered pixel per active pixel strobe (16bpp or 8bpp).
module video_fetch
  import video_fetch_pkg::*;
#(
  parameter int addrBits      = 25,
  parameter int burstWords    = DEFAULT_BURST_WORDS,
  parameter int fifoDepthLog2 = 5,
  parameter int lineBits      = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pixel_stb,
  input  logic                hblank_n,
  input  logic                vblank_n,
  input  logic                frame_stb,
  input  logic [addrBits-1:0] fb_base,
  input  logic [lineBits-1:0] line_words,
  input  logic [lineBits-1:0] stride,
  input  logic                bpp8,
  output logic                mem_req,
  output logic [addrBits-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [15:0]         mem_data,
  input  logic                mem_data_stb,
  output logic [15:0]         pixel,
  output logic                underflow
);

  localparam int BEAT_BITS = $clog2(burstWords);
  localparam logic [fifoDepthLog2:0] BURST_FREE = (fifoDepthLog2 + 1)'(burstWords);

  fetch_state_t          state_reg, state_next;
  logic                  mem_req_reg, mem_req_next;
  logic [addrBits-1:0]   mem_addr_reg, mem_addr_next;
  logic [addrBits-1:0]   row_addr_reg;
  logic [lineBits-1:0]   word_off_reg;
  logic [lineBits-1:0]   line_words_reg;
  logic [lineBits-1:0]   stride_reg;
  logic                  bpp8_reg;
  logic [BEAT_BITS-1:0]  beat_cnt_reg;
  logic                  drop_reg;
  logic [15:0]           pixel_reg;
  logic                  underflow_reg;
  logic                  byte_sel_reg;

  logic                    active;
  logic                    last_beat;
  logic                    push;
  logic                    line_end;
  logic                    pop;
  logic                    fifo_empty;
  logic [15:0]             fifo_head;
  logic [fifoDepthLog2:0]  fifo_count;
  logic [fifoDepthLog2:0]  fifo_free;

  assign active     = hblank_n & vblank_n;
  assign fifo_empty = (fifo_count == '0);
  assign last_beat  = (beat_cnt_reg == BEAT_BITS'(burstWords - 1));
  // drop_reg covers both the tail of a line's last burst and a burst orphaned by frame_stb.
  assign push       = (state_reg == DATA) && mem_data_stb && !drop_reg && !frame_stb;
  assign line_end   = push && ((word_off_reg + lineBits'(1)) == line_words_reg);
  assign pop        = pixel_stb && active && !fifo_empty && (!bpp8_reg || byte_sel_reg);

  video_fetch_fifo #(
    .WIDTH      (16),
    .DEPTH_LOG2 (fifoDepthLog2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (mem_data),
    .pop       (pop),
    .flush     (frame_stb),
    .head      (fifo_head),
    .count     (fifo_count),
    .free      (fifo_free)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    case (state_reg)
      IDLE: begin
        if (frame_stb) state_next = CHECK;
      end
      CHECK: begin
        if (fifo_free >= BURST_FREE) begin
          state_next    = REQ;
          mem_req_next  = 1'b1;
          mem_addr_next = frame_stb ? fb_base : row_addr_reg + addrBits'(word_off_reg);
        end
      end
      REQ: begin
        if (frame_stb) mem_addr_next = fb_base;
        if (mem_ack) begin
          mem_req_next = 1'b0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (mem_data_stb && last_beat) state_next = CHECK;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_addr_reg   <= '0;
      word_off_reg   <= '0;
      line_words_reg <= '0;
      stride_reg     <= '0;
      bpp8_reg       <= 1'b0;
      beat_cnt_reg   <= '0;
      drop_reg       <= 1'b0;
    end else begin
      if (frame_stb) begin
        row_addr_reg   <= fb_base;
        word_off_reg   <= '0;
        line_words_reg <= line_words;
        stride_reg     <= stride;
        bpp8_reg       <= bpp8;
      end else if (line_end) begin
        row_addr_reg <= row_addr_reg + addrBits'(stride_reg);
        word_off_reg <= '0;
      end else if (push) begin
        word_off_reg <= word_off_reg + lineBits'(1);
      end

      if ((state_reg == REQ) && mem_ack) begin
        beat_cnt_reg <= '0;
        drop_reg     <= 1'b0;
      end else if (state_reg == DATA) begin
        if (mem_data_stb) beat_cnt_reg <= beat_cnt_reg + BEAT_BITS'(1);
        if (frame_stb || line_end) drop_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_reg     <= '0;
      underflow_reg <= 1'b0;
      byte_sel_reg  <= 1'b0;
    end else begin
      if (pixel_stb) begin
        if (!active) begin
          pixel_reg <= '0;
        end else if (fifo_empty) begin
          pixel_reg     <= '0;
          underflow_reg <= 1'b1;
        end else if (bpp8_reg && !byte_sel_reg) begin
          pixel_reg    <= {8'h00, fifo_head[7:0]};
          byte_sel_reg <= 1'b1;
        end else if (bpp8_reg) begin
          pixel_reg    <= {8'h00, fifo_head[15:8]};
          byte_sel_reg <= 1'b0;
        end else begin
          pixel_reg <= fifo_head;
        end
      end
      if (frame_stb) begin
        underflow_reg <= 1'b0;
        byte_sel_reg  <= 1'b0;
      end
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_addr  = mem_addr_reg;
  assign pixel     = pixel_reg;
  assign underflow = underflow_reg;

endmodule

// File: doc/video_fetch.md
Name: video_fetch

Overview:
Downstream consumer of the video timing generator's strobes: prefetches framebuffer words from memory through a burst request/ack port into a small FIFO.
Pops one pixel per active `pixel_stb` so colour data lines up with the sync/blank outputs.
Sits between the SDRAM arbiter client port and the scandoubler/VGA output mux.
Supports 16bpp (one pixel per word) and 8bpp (two pixels per word, low byte first).

Parameters:
addrBits, 25, memory word-address width
burstWords, 8, words per memory burst (power of two)
fifoDepthLog2, 5, log2 of FIFO depth in 16-bit words; must be ≥ log2(burstWords)+1
lineBits, 12, width of line-length and stride inputs

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pixel_stb  in  1  one-cycle pixel strobe from timing generator
hblank_n  in  1  high during active horizontal region
vblank_n  in  1  high during active vertical region
frame_stb  in  1  new-frame-imminent strobe
fb_base  in  addrBits  framebuffer start word address, sampled at frame_stb
line_words  in  lineBits  words fetched per line, sampled at frame_stb, nonzero
stride  in  lineBits  word distance between line starts, sampled at frame_stb
bpp8  in  1  1 = 8bpp, 0 = 16bpp, sampled at frame_stb
mem_req  out  1  burst request, held until mem_ack
mem_addr  out  addrBits  burst start word address, stable while mem_req
mem_ack  in  1  one-cycle request acceptance
mem_data  in  16  burst data word
mem_data_stb  in  1  mem_data valid; exactly burstWords pulses per accepted request, gaps allowed
pixel  out  16  current pixel (8bpp: zero-extended byte)
underflow  out  1  sticky: pop attempted on empty FIFO; cleared at frame_stb

Behaviour:
- **Reset (async, all zero):** mem_req, mem_addr, pixel, underflow, FIFO empty, state IDLE, pointers zero, byte select 0.
- **Fetch FSM states:**
  - IDLE: before the first frame_stb; nothing fetched.
  - CHECK: if FIFO free words minus words still due from the outstanding burst ≥ burstWords, assert mem_req with mem_addr = row_addr + word_off; go to REQ.
  - REQ: hold mem_req and mem_addr until mem_ack. On mem_ack, drop mem_req in the next cycle and go to DATA.
  - DATA: count mem_data_stb pulses. After the burstWords-th pulse, go to CHECK. Only one burst is ever outstanding.
- **Data push and line advance:**
  - Each mem_data_stb pushes mem_data while word_off < line_words; word_off increments per pushed word.
  - Words beyond line_words in a line's last burst are discarded, not pushed.
  - When word_off reaches line_words: row_addr += stride (wraps modulo 2^addrBits) and word_off = 0. The next burst starts at the new row.
  - A burst never spans two lines.
  - Fetching runs ahead across hblank/vblank, limited only by FIFO space.
- **Frame start (frame_stb):**
  - Flush the FIFO, clear underflow and byte select.
  - Load row_addr = fb_base, word_off = 0, and latch line_words, stride, bpp8.
  - If mem_req is pending: keep requesting, but re-target mem_addr to fb_base on the same cycle.
  - If in DATA: the remaining words of that burst are counted and discarded; the FSM returns to CHECK afterwards.
  - From IDLE: go to CHECK.
- **Pixel pop:**
  - On pixel_stb with hblank_n & vblank_n:
    - 16bpp: pop one word; pixel = word.
    - 8bpp: byte select 0 → pixel = {8'h00, word[7:0]}, no pop. Byte select 1 → pixel = {8'h00, word[15:8]}, pop. Byte select toggles.
  - pixel is registered: valid the cycle after pixel_stb, held until the next pixel_stb.
  - On pixel_stb while blanked: pixel = 0, no pop.
  - Pop on empty FIFO: pixel = 0, underflow set, no pointer change.
- **FIFO:** simultaneous push and pop in one cycle is legal; count unchanged. Push when full cannot occur by construction; assert in simulation.
- mem_ack or mem_data_stb outside REQ/DATA respectively is ignored.

Decomposition:
- Add to the shared video package:
  - typedef fetch_state_t {IDLE, CHECK, REQ, DATA};
  - the constant default burst length.
- One sub-module, video_fetch_fifo: synchronous FIFO with push, pop, flush, full count and free count, parameterised by width and depth; inferable as block RAM.

Test Plan:
- Reset, then frame_stb with fb_base=0x1000, line_words=16, stride=32, burstWords=8 → requests at 0x1000, 0x1008, then 0x1020, 0x1028; stops when FIFO free < 8.
- line_words=12, burstWords=8 → second burst at base+8 delivers 8 words, only 4 pushed; next request at base+stride.
- 16bpp, FIFO preloaded with 0xA1B2, 0xC3D4; two active pixel_stb → pixel 0xA1B2 then 0xC3D4. 8bpp same data → 0x00B2, 0x00A1, 0x00D4, 0x00C3.
- Memory stalled (mem_ack never asserted), 3 active pixel_stb → pixel 0 each time, underflow=1; next frame_stb → underflow=0.
- frame_stb arrives mid-DATA after 3 of 8 words → remaining 5 discarded, FIFO empty; next request address = new fb_base.
- reset_n pulsed low mid-burst, asynchronously → mem_req=0 and pixel=0 immediately; FSM IDLE until the next frame_stb.
